// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer and the immediate unit.
// Also holds the opcode constants, instruction classes and FSM state encoding.
package mc_ctrl_pkg;

   localparam logic [2:0] SEXT_NONE = 3'd0;
   localparam logic [2:0] SEXT_I    = 3'd1;
   localparam logic [2:0] SEXT_S    = 3'd2;
   localparam logic [2:0] SEXT_B    = 3'd3;
   localparam logic [2:0] SEXT_U    = 3'd4;
   localparam logic [2:0] SEXT_J    = 3'd5;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MEM  = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;
   localparam logic [1:0] WB_IMM  = 2'd3;

   localparam logic [1:0] NPC_PC4  = 2'd0;
   localparam logic [1:0] NPC_BR   = 2'd1;
   localparam logic [1:0] NPC_JAL  = 2'd2;
   localparam logic [1:0] NPC_JALR = 2'd3;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [3:0] {
      CLS_ILL, CLS_R, CLS_IALU, CLS_LOAD, CLS_STORE,
      CLS_BRANCH, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR
   } cls_e;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_e;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode classifier: instruction class, immediate format,
// operand/write-back/next-PC selects and a legal flag.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output cls_e       cls,
   output logic [2:0] sext_op,
   output logic       alu_b_sel,
   output logic [1:0] wb_sel,
   output logic [1:0] npc_sel,
   output logic       legal
);

   always_comb begin
      cls       = CLS_ILL;
      sext_op   = SEXT_NONE;
      alu_b_sel = 1'b0;
      wb_sel    = WB_ALU;
      npc_sel   = NPC_PC4;
      legal     = 1'b1;
      case (opcode)
         OP_R:      cls = CLS_R;
         OP_IALU:   begin cls = CLS_IALU;  sext_op = SEXT_I; alu_b_sel = 1'b1; end
         OP_LOAD:   begin cls = CLS_LOAD;  sext_op = SEXT_I; alu_b_sel = 1'b1; wb_sel = WB_MEM; end
         OP_STORE:  begin cls = CLS_STORE; sext_op = SEXT_S; alu_b_sel = 1'b1; end
         OP_BRANCH: begin cls = CLS_BRANCH; sext_op = SEXT_B; end
         OP_LUI:    begin cls = CLS_LUI;   sext_op = SEXT_U; alu_b_sel = 1'b1; wb_sel = WB_IMM; end
         OP_AUIPC:  begin cls = CLS_AUIPC; sext_op = SEXT_U; alu_b_sel = 1'b1; end
         OP_JAL:    begin cls = CLS_JAL;   sext_op = SEXT_J; wb_sel = WB_PC4; npc_sel = NPC_JAL; end
         OP_JALR:   begin
            cls = CLS_JALR; sext_op = SEXT_I; alu_b_sel = 1'b1;
            wb_sel = WB_PC4; npc_sel = NPC_JALR;
         end
         default:   legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control sequencer with retired-instruction counter.
// Define MC_ILLEGAL_TRAP_EN to trap on unknown opcodes; otherwise they retire as NOPs.
//
// state  | meaning
// IDLE   | post-reset, moves to FETCH next cycle
// FETCH  | imem request held until imem_ack, IR loaded on ack
// DECODE | classify opcode, register immediate format and selects
// EXEC   | branch resolves and retires; others route to MEM or WB
// MEM    | dmem request held until dmem_ack; stores retire on ack
// WB     | register-file write, PC update, retire
// TRAP   | illegal opcode, all strobes low until reset
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           opcode,
   input  logic                 br_taken,
   input  logic                 imem_ack,
   input  logic                 dmem_ack,
   output logic                 imem_req,
   output logic                 ir_we,
   output logic [2:0]           sext_op,
   output logic                 alu_b_sel,
   output logic [1:0]           wb_sel,
   output logic [1:0]           npc_sel,
   output logic                 pc_we,
   output logic                 rf_we,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic                 illegal,
   output logic [INSTRET_W-1:0] instret
);

   state_e     state;
   cls_e       cls_q;
   logic [1:0] npc_q;

   cls_e       dec_cls;
   logic [2:0] dec_sext;
   logic       dec_alu_b;
   logic [1:0] dec_wb;
   logic [1:0] dec_npc;
   logic       dec_legal;
   logic       nop_retire;
   logic       is_branch;
   logic       is_store;

   mc_ctrl_decode u_decode (
      .opcode    (opcode),
      .cls       (dec_cls),
      .sext_op   (dec_sext),
      .alu_b_sel (dec_alu_b),
      .wb_sel    (dec_wb),
      .npc_sel   (dec_npc),
      .legal     (dec_legal)
   );

   assign is_branch = (cls_q == CLS_BRANCH);
   assign is_store  = (cls_q == CLS_STORE);

`ifdef MC_ILLEGAL_TRAP_EN
   assign nop_retire = 1'b0;
`else
   assign nop_retire = (state == S_DECODE) && !dec_legal;
   assign illegal    = 1'b0;
`endif

   // Strobes decode the async-reset state register, so reset drops them at once.
   always_comb begin
      imem_req = (state == S_FETCH);
      ir_we    = imem_req && imem_ack;
      dmem_req = (state == S_MEM);
      dmem_we  = dmem_req && is_store;
      rf_we    = (state == S_WB);
      pc_we    = rf_we
               || ((state == S_EXEC) && is_branch)
               || (dmem_req && dmem_ack && is_store)
               || nop_retire;
      if (nop_retire)
         npc_sel = NPC_PC4;
      else if ((state == S_EXEC) && is_branch)
         npc_sel = br_taken ? NPC_BR : NPC_PC4;
      else
         npc_sel = npc_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cls_q     <= CLS_ILL;
         sext_op   <= SEXT_NONE;
         alu_b_sel <= 1'b0;
         wb_sel    <= WB_ALU;
         npc_q     <= NPC_PC4;
         instret   <= '0;
`ifdef MC_ILLEGAL_TRAP_EN
         illegal   <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE:   state <= S_FETCH;
            S_FETCH:  if (imem_ack) state <= S_DECODE;
            S_DECODE: begin
               cls_q     <= dec_cls;
               sext_op   <= dec_sext;
               alu_b_sel <= dec_alu_b;
               wb_sel    <= dec_wb;
               npc_q     <= dec_npc;
               if (dec_legal)
                  state <= S_EXEC;
               else begin
`ifdef MC_ILLEGAL_TRAP_EN
                  state   <= S_TRAP;
                  illegal <= 1'b1;
`else
                  state   <= S_FETCH;
`endif
               end
            end
            S_EXEC: begin
               if (is_branch)
                  state <= S_FETCH;
               else if ((cls_q == CLS_LOAD) || is_store)
                  state <= S_MEM;
               else
                  state <= S_WB;
            end
            S_MEM:    if (dmem_ack) state <= is_store ? S_FETCH : S_WB;
            S_WB:     state <= S_FETCH;
            S_TRAP:   state <= S_TRAP;
            default:  state <= S_IDLE;
         endcase
         // Every retire point coincides with a PC update.
         if (pc_we)
            instret <= instret + INSTRET_W'(1);
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl; follows MC_ILLEGAL_TRAP_EN for the illegal-opcode case.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  opcode;
   logic        br_taken;
   logic        imem_ack;
   logic        dmem_ack;
   logic        imem_req;
   logic        ir_we;
   logic [2:0]  sext_op;
   logic        alu_b_sel;
   logic [1:0]  wb_sel;
   logic [1:0]  npc_sel;
   logic        pc_we;
   logic        rf_we;
   logic        dmem_req;
   logic        dmem_we;
   logic        illegal;
   logic [31:0] instret;

   int checks = 0;
   int errors = 0;

   mc_ctrl #(.INSTRET_W(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we),
      .sext_op(sext_op), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel), .npc_sel(npc_sel),
      .pc_we(pc_we), .rf_we(rf_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .illegal(illegal), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then settle inputs 2 time units after the edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1; opcode = 7'd0; br_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      #3;
      chk("rst_imem_req", imem_req, 0);
      chk("rst_strobes", {ir_we, pc_we, rf_we, dmem_req, dmem_we}, 0);
      chk("rst_sels", {sext_op, alu_b_sel, wb_sel, npc_sel}, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_instret", instret, 0);
      #9 rst = 1'b0;

      // ADDI, zero wait
      cyc(); imem_ack = 1'b1; opcode = 7'b0010011; #1;
      chk("addi_f_req", imem_req, 1);
      chk("addi_f_irwe", ir_we, 1);
      cyc(); imem_ack = 1'b0; #1;
      chk("addi_d_irwe", ir_we, 0);
      chk("addi_d_pcwe", pc_we, 0);
      cyc(); #1;
      chk("addi_e_sext", sext_op, 1);
      chk("addi_e_alub", alu_b_sel, 1);
      chk("addi_e_rfwe", rf_we, 0);
      cyc(); #1;
      chk("addi_wb_rfwe", rf_we, 1);
      chk("addi_wb_pcwe", pc_we, 1);
      chk("addi_wb_wbsel", wb_sel, 0);
      chk("addi_wb_instret", instret, 0);
      cyc(); #1;
      chk("addi_done_instret", instret, 1);
      chk("addi_done_rfwe", rf_we, 0);
      chk("addi_done_req", imem_req, 1);

      // LW, dmem_ack after 3 wait cycles
      imem_ack = 1'b1; opcode = 7'b0000011; #1;
      chk("lw_f_irwe", ir_we, 1);
      cyc(); imem_ack = 1'b0; #1;
      cyc(); #1;
      chk("lw_e_dreq", dmem_req, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(); #1;
         chk("lw_m_wait_req", dmem_req, 1);
         chk("lw_m_wait_we", dmem_we, 0);
         chk("lw_m_wait_rfwe", rf_we, 0);
      end
      cyc(); dmem_ack = 1'b1; #1;
      chk("lw_m_ack_req", dmem_req, 1);
      chk("lw_m_ack_pcwe", pc_we, 0);
      cyc(); dmem_ack = 1'b0; #1;
      chk("lw_wb_rfwe", rf_we, 1);
      chk("lw_wb_wbsel", wb_sel, 1);
      chk("lw_wb_sext", sext_op, 1);
      chk("lw_wb_dreq", dmem_req, 0);
      cyc(); #1;
      chk("lw_done_instret", instret, 2);
      chk("lw_done_req", imem_req, 1);

      // BEQ taken
      imem_ack = 1'b1; opcode = 7'b1100011; #1;
      cyc(); imem_ack = 1'b0; #1;
      cyc(); br_taken = 1'b1; #1;
      chk("beq_t_sext", sext_op, 3);
      chk("beq_t_pcwe", pc_we, 1);
      chk("beq_t_npc", npc_sel, 1);
      chk("beq_t_rfwe", rf_we, 0);
      cyc(); br_taken = 1'b0; #1;
      chk("beq_t_req", imem_req, 1);
      chk("beq_t_instret", instret, 3);

      // BEQ not taken
      imem_ack = 1'b1; #1;
      cyc(); imem_ack = 1'b0; #1;
      cyc(); br_taken = 1'b0; #1;
      chk("beq_n_pcwe", pc_we, 1);
      chk("beq_n_npc", npc_sel, 0);
      chk("beq_n_rfwe", rf_we, 0);
      cyc(); #1;
      chk("beq_n_req", imem_req, 1);
      chk("beq_n_instret", instret, 4);

      // SW with one imem wait cycle
      opcode = 7'b0100011; #1;
      chk("sw_fwait_req", imem_req, 1);
      chk("sw_fwait_irwe", ir_we, 0);
      cyc(); imem_ack = 1'b1; #1;
      chk("sw_f_irwe", ir_we, 1);
      cyc(); imem_ack = 1'b0; #1;
      cyc(); #1;
      chk("sw_e_sext", sext_op, 2);
      cyc(); dmem_ack = 1'b1; #1;
      chk("sw_m_req", dmem_req, 1);
      chk("sw_m_we", dmem_we, 1);
      chk("sw_m_pcwe", pc_we, 1);
      chk("sw_m_rfwe", rf_we, 0);
      cyc(); dmem_ack = 1'b0; #1;
      chk("sw_done_req", imem_req, 1);
      chk("sw_done_instret", instret, 5);

      // JAL; imem_ack left high in DECODE must be ignored
      imem_ack = 1'b1; opcode = 7'b1101111; #1;
      cyc(); #1;
      chk("jal_d_irwe_ignored", ir_we, 0);
      cyc(); imem_ack = 1'b0; #1;
      chk("jal_e_sext", sext_op, 5);
      chk("jal_e_wbsel", wb_sel, 2);
      chk("jal_e_npc", npc_sel, 2);
      chk("jal_e_pcwe", pc_we, 0);
      cyc(); #1;
      chk("jal_wb_rfwe", rf_we, 1);
      chk("jal_wb_npc", npc_sel, 2);
      cyc(); #1;
      chk("jal_done_instret", instret, 6);

      // LW aborted by reset while in MEM
      imem_ack = 1'b1; opcode = 7'b0000011; #1;
      cyc(); imem_ack = 1'b0; #1;
      cyc(); #1;
      cyc(); #1;
      chk("abort_m_req", dmem_req, 1);
      #1 rst = 1'b1;
      #1;
      chk("abort_dreq", dmem_req, 0);
      chk("abort_instret", instret, 0);
      chk("abort_sext", sext_op, 0);
      #1 rst = 1'b0;
      #1;
      chk("abort_idle_req", imem_req, 0);
      cyc(); #1;
      chk("abort_fetch_req", imem_req, 1);
      chk("abort_fetch_instret", instret, 0);

      // Unknown opcode 1111111
      imem_ack = 1'b1; opcode = 7'b1111111; #1;
      cyc(); imem_ack = 1'b0; #1;
`ifdef MC_ILLEGAL_TRAP_EN
      chk("ill_d_pcwe", pc_we, 0);
      cyc(); #1;
      chk("ill_trap_flag", illegal, 1);
      chk("ill_trap_req", imem_req, 0);
      imem_ack = 1'b1; dmem_ack = 1'b1;
      cyc(); #1;
      chk("ill_trap_stuck_req", {imem_req, ir_we, pc_we, rf_we, dmem_req, dmem_we}, 0);
      chk("ill_trap_instret", instret, 0);
      imem_ack = 1'b0; dmem_ack = 1'b0;
`else
      chk("ill_d_pcwe", pc_we, 1);
      chk("ill_d_npc", npc_sel, 0);
      chk("ill_d_flag", illegal, 0);
      cyc(); #1;
      chk("ill_next_req", imem_req, 1);
      chk("ill_instret", instret, 1);
      imem_ack = 1'b1; opcode = 7'b0010011; #1;
      chk("ill_next_irwe", ir_we, 1);
      cyc(); imem_ack = 1'b0; #1;
      cyc(); #1;
      cyc(); #1;
      chk("ill_addi_rfwe", rf_we, 1);
      cyc(); #1;
      chk("ill_addi_instret", instret, 2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
